tour_cmd_seq: RTL and testbench
===============================

Name: tour_cmd_seq

Overview:
Downstream of the knight's-tour solver. After the solver pulses done, this block reads the solved moves back one at a time through the solver's index/move read port. It converts each one-hot knight move into two motion commands: a vertical leg, then a horizontal leg with fanfare. It issues them to the command processor with a ready/clear/response handshake. Outside a tour it transparently passes UART commands through to the command processor.

Parameters:
NUM_MOVES, 24, number of moves in a tour; last index is NUM_MOVES-1
OPC_MOVE, 4'h2, opcode for plain move, used on the vertical leg
OPC_FANFARE, 4'h3, opcode for move-with-fanfare, used on the horizontal leg

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_tour  in  1  1-cycle pulse from solver done; begins playback
move  in  8  one-hot move read from solver at mv_indx
mv_indx  out  5  index of move being played
cmd_UART  in  16  command from UART wrapper
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy_UART  out  1  clear to UART wrapper
cmd  out  16  command to command processor
cmd_rdy  out  1  cmd valid
clr_cmd_rdy  in  1  command processor accepted cmd
send_resp  in  1  command processor finished a command (pulse)
resp  out  8  response byte to host

Behaviour:
- Reset is asynchronous on rst_n low, clocked on clk. On reset: state=IDLE, mv_indx=0. Outputs then follow the IDLE muxing: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5.
- Move encoding (bit: dx,dy): 0:(-1,+2) 1:(+1,+2) 2:(-2,+1) 3:(-2,-1) 4:(-1,-2) 5:(+1,-2) 6:(+2,-1) 7:(+2,+1). +y is north, +x is east.
- Command format: cmd[15:12]=opcode, cmd[11:4]=heading, cmd[3:0]=squares.
  - Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
  - Vertical cmd = {OPC_MOVE, dy>0?N:S, |dy|}.
  - Horizontal cmd = {OPC_FANFARE, dx>0?E:W, |dx|}.
  - A non-one-hot move yields cmd = {opcode, 8'h00, 4'h0}. No error flag.
- States: IDLE, VERT, HOLD_V, HORZ, HOLD_H.
  - IDLE: UART pass-through. On start_tour: mv_indx<=0, go to VERT.
  - VERT: cmd=vertical cmd, cmd_rdy=1. On clr_cmd_rdy go to HOLD_V.
  - HOLD_V: cmd_rdy=0, cmd held. On send_resp go to HORZ.
  - HORZ: cmd=horizontal cmd, cmd_rdy=1. On clr_cmd_rdy go to HOLD_H.
  - HOLD_H: cmd_rdy=0. On send_resp: if mv_indx==NUM_MOVES-1 go to IDLE and reset mv_indx to 0; else mv_indx+1 and go to VERT.
- cmd and cmd_rdy are combinational from state and move. move is valid at the current mv_indx with zero added latency.
- UART side during a tour:
  - clr_cmd_rdy_UART=0 in every non-IDLE state; cmd_rdy_UART is ignored.
  - A UART command arriving mid-tour stays pending and is passed through on return to IDLE.
- resp: 8'hA5 in IDLE, and in HOLD_H when mv_indx==NUM_MOVES-1; otherwise 8'h5A.
- Ignored inputs:
  - start_tour outside IDLE is ignored.
  - send_resp in VERT or HORZ (before clr_cmd_rdy) is ignored.
  - clr_cmd_rdy in HOLD states is ignored.
- Same-cycle events: clr_cmd_rdy and send_resp in the same cycle in VERT → go to HOLD_V only; the send_resp is not remembered.
- Reset mid-tour: immediate return to IDLE with mv_indx=0. No command remains asserted.

Test Plan:
- Reset, then drive cmd_UART=16'h2345 with cmd_rdy_UART=1 and pulse clr_cmd_rdy → cmd=16'h2345, cmd_rdy=1, clr_cmd_rdy_UART pulses, resp=8'hA5.
- start_tour with move=8'h01 → cmd=16'h2002 with cmd_rdy=1. After clr_cmd_rdy then send_resp → cmd=16'h33F1 with cmd_rdy=1.
- move=8'h40: vertical cmd=16'h27F1, horizontal cmd=16'h3BF2. resp=8'h5A between legs.
- Full 24-move playback with a responder model → 48 commands issued and mv_indx steps 0..23. resp=8'hA5 on the final send_resp, then IDLE with UART pass-through restored.
- cmd_rdy_UART asserted mid-tour → cmd never equals cmd_UART and clr_cmd_rdy_UART stays 0 until IDLE, then the pending command passes through.
- rst_n low while in HOLD_H at mv_indx=10 → state=IDLE, mv_indx=0, cmd_rdy equals cmd_rdy_UART. A later start_tour restarts from index 0.

Source files
------------

// File: rtl/tour_cmd_seq.sv
// Plays back a solved knight's tour as vertical/horizontal motion commands,
// and passes UART commands straight through to the command processor when idle.
module tour_cmd_seq #(
  parameter int unsigned NUM_MOVES   = 24,
  parameter logic [3:0]  OPC_MOVE    = 4'h2,
  parameter logic [3:0]  OPC_FANFARE = 4'h3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam int unsigned IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    HOLD_V = 3'd2,
    HORZ   = 3'd3,
    HOLD_H = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] mv_indx_q, mv_indx_d;

  logic [7:0]  v_head, h_head;
  logic [3:0]  v_sq, h_sq;
  logic [15:0] vert_cmd, horz_cmd;
  logic        last_move;

  assign mv_indx   = mv_indx_q;
  assign last_move = (mv_indx_q == LAST_IDX);

  // One-hot move to leg headings/lengths; anything else decodes to zero legs
  always_comb begin
    v_head = 8'h00;
    v_sq   = 4'h0;
    h_head = 8'h00;
    h_sq   = 4'h0;
    case (move)
      8'b0000_0001: begin v_head = HEAD_N; v_sq = 4'd2; h_head = HEAD_W; h_sq = 4'd1; end
      8'b0000_0010: begin v_head = HEAD_N; v_sq = 4'd2; h_head = HEAD_E; h_sq = 4'd1; end
      8'b0000_0100: begin v_head = HEAD_N; v_sq = 4'd1; h_head = HEAD_W; h_sq = 4'd2; end
      8'b0000_1000: begin v_head = HEAD_S; v_sq = 4'd1; h_head = HEAD_W; h_sq = 4'd2; end
      8'b0001_0000: begin v_head = HEAD_S; v_sq = 4'd2; h_head = HEAD_W; h_sq = 4'd1; end
      8'b0010_0000: begin v_head = HEAD_S; v_sq = 4'd2; h_head = HEAD_E; h_sq = 4'd1; end
      8'b0100_0000: begin v_head = HEAD_S; v_sq = 4'd1; h_head = HEAD_E; h_sq = 4'd2; end
      8'b1000_0000: begin v_head = HEAD_N; v_sq = 4'd1; h_head = HEAD_E; h_sq = 4'd2; end
      default: ;
    endcase
  end

  assign vert_cmd = {OPC_MOVE, v_head, v_sq};
  assign horz_cmd = {OPC_FANFARE, h_head, h_sq};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= '0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  // Next state: each leg waits for accept (clr_cmd_rdy), then completion (send_resp)
  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    case (state_q)
      IDLE: begin
        if (start_tour) begin
          state_d   = VERT;
          mv_indx_d = '0;
        end
      end
      VERT:   if (clr_cmd_rdy) state_d = HOLD_V;
      HOLD_V: if (send_resp)   state_d = HORZ;
      HORZ:   if (clr_cmd_rdy) state_d = HOLD_H;
      HOLD_H: begin
        if (send_resp) begin
          if (last_move) begin
            state_d   = IDLE;
            mv_indx_d = '0;
          end else begin
            state_d   = VERT;
            mv_indx_d = mv_indx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mv_indx_d = '0;
      end
    endcase
  end

  // Outputs: UART pass-through only in IDLE; the UART side is held off mid-tour
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_BUSY;
    case (state_q)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
      end
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
      end
      HOLD_V: cmd = vert_cmd;
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
      end
      HOLD_H: begin
        cmd  = horz_cmd;
        resp = last_move ? RESP_DONE : RESP_BUSY;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq: UART pass-through, leg decoding, full tour
// playback with handshakes, ignored/same-cycle events and mid-tour reset.
module tb_tour_cmd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_cmds = 0;

  logic [7:0]  tbl [32];
  // Hand-derived legs for one-hot move bit k
  logic [15:0] exp_v [8] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1,
                             16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
  logic [15:0] exp_h [8] = '{16'h33F1, 16'h3BF1, 16'h33F2, 16'h33F2,
                             16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};

  tour_cmd_seq dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  always #5 clk = ~clk;

  // Solver read port: move at mv_indx with no latency
  always_comb move = tbl[mv_indx];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    #1;
  endtask

  task automatic pulse_resp();
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    #1;
  endtask

  task automatic start();
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
    #1;
  endtask

  // One move: both legs with the responder handshake; probe is for ignored events
  task automatic play_move(input int i, input bit last, input bit probe);
    chk("v_indx", 32'(mv_indx), 32'(i));
    chk("v_cmd", 32'(cmd), 32'(exp_v[i % 8]));
    chk("v_rdy", 32'(cmd_rdy), 32'd1);
    chk("v_resp", 32'(resp), 32'h5A);
    chk("v_uart_clr", 32'(clr_cmd_rdy_UART), 32'd0);
    chk("v_no_pass", 32'(cmd == cmd_UART), 32'd0);
    if (probe) begin
      pulse_resp();
      chk("v_resp_ignored", 32'(cmd_rdy), 32'd1);
      chk("v_resp_ign_cmd", 32'(cmd), 32'(exp_v[i % 8]));
      clr_cmd_rdy = 1'b1;
      send_resp   = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      send_resp   = 1'b0;
      #1;
      chk("same_cyc_rdy", 32'(cmd_rdy), 32'd0);
      @(negedge clk);
      #1;
      chk("same_cyc_held", 32'(cmd), 32'(exp_v[i % 8]));
      pulse_clr();
      chk("hv_clr_ignored", 32'(cmd_rdy), 32'd0);
    end else begin
      pulse_clr();
    end
    n_cmds++;
    chk("hv_rdy", 32'(cmd_rdy), 32'd0);
    chk("hv_cmd", 32'(cmd), 32'(exp_v[i % 8]));
    chk("hv_resp", 32'(resp), 32'h5A);
    pulse_resp();
    chk("h_cmd", 32'(cmd), 32'(exp_h[i % 8]));
    chk("h_rdy", 32'(cmd_rdy), 32'd1);
    chk("h_resp", 32'(resp), 32'h5A);
    chk("h_uart_clr", 32'(clr_cmd_rdy_UART), 32'd0);
    if (probe) begin
      start();
      chk("start_ignored_idx", 32'(mv_indx), 32'(i));
      chk("start_ignored_cmd", 32'(cmd), 32'(exp_h[i % 8]));
    end
    pulse_clr();
    n_cmds++;
    chk("hh_rdy", 32'(cmd_rdy), 32'd0);
    chk("hh_resp", 32'(resp), last ? 32'hA5 : 32'h5A);
    pulse_resp();
  endtask

  initial begin
    for (int k = 0; k < 32; k++) tbl[k] = 8'(1 << (k % 8));
    rst_n        = 1'b0;
    start_tour   = 1'b0;
    cmd_UART     = 16'h2345;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_indx", 32'(mv_indx), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'h2345);
    chk("rst_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_resp", 32'(resp), 32'hA5);
    @(negedge clk);
    rst_n       = 1'b1;
    clr_cmd_rdy = 1'b1;
    #1;
    chk("idle_clr_pass", 32'(clr_cmd_rdy_UART), 32'd1);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    #1;
    chk("idle_clr_drop", 32'(clr_cmd_rdy_UART), 32'd0);

    // Full tour; a UART command is pending the whole time
    cmd_UART     = 16'h1234;
    cmd_rdy_UART = 1'b1;
    start();
    for (int i = 0; i < 24; i++) play_move(i, i == 23, i == 0);
    chk("n_cmds", 32'(n_cmds), 32'd48);
    chk("end_indx", 32'(mv_indx), 32'd0);
    chk("end_cmd_pass", 32'(cmd), 32'h1234);
    chk("end_rdy_pass", 32'(cmd_rdy), 32'd1);
    chk("end_resp", 32'(resp), 32'hA5);
    clr_cmd_rdy = 1'b1;
    #1;
    chk("end_clr_pass", 32'(clr_cmd_rdy_UART), 32'd1);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    #1;

    // Reset while in HOLD_H of move 10
    start();
    for (int i = 0; i < 10; i++) play_move(i, 1'b0, 1'b0);
    chk("m10_indx", 32'(mv_indx), 32'd10);
    pulse_clr();
    pulse_resp();
    pulse_clr();
    chk("m10_hold_h", 32'(cmd), 32'(exp_h[2]));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_indx", 32'(mv_indx), 32'd0);
    chk("mid_rst_rdy1", 32'(cmd_rdy), 32'd1);
    chk("mid_rst_cmd", 32'(cmd), 32'h1234);
    cmd_rdy_UART = 1'b0;
    #1;
    chk("mid_rst_rdy0", 32'(cmd_rdy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    start();
    chk("restart_indx", 32'(mv_indx), 32'd0);
    chk("restart_cmd", 32'(cmd), 32'h2002);
    chk("restart_rdy", 32'(cmd_rdy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
